// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised raster timing generator. Produces the pixel-tick
//            strobe, hpos/vpos counters, sync, display-enable and line/frame
//            strobes. Sync polarity is selectable, run freezes the timing,
//            and an N_PIPE-tick delay line aligns the status outputs with
//            downstream pixel-pipeline latency.
// Options  : define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int HPOS_WIDTH = 11,
  parameter int VPOS_WIDTH = 10,
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 2,
  parameter int N_PIPE     = 0,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  pixel_en,
  output logic [HPOS_WIDTH-1:0] hpos,
  output logic [VPOS_WIDTH-1:0] vpos,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  display_on,
  output logic                  line_start,
  output logic                  frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam int C_H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [C_DIV_W-1:0]    C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
  localparam logic [HPOS_WIDTH-1:0] C_H_LAST   = HPOS_WIDTH'(C_H_TOTAL - 1);
  localparam logic [HPOS_WIDTH-1:0] C_H_DISP   = HPOS_WIDTH'(H_DISPLAY);
  localparam logic [HPOS_WIDTH-1:0] C_HS_FIRST = HPOS_WIDTH'(H_DISPLAY + H_FRONT);
  localparam logic [HPOS_WIDTH-1:0] C_HS_LAST  = HPOS_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [VPOS_WIDTH-1:0] C_V_LAST   = VPOS_WIDTH'(C_V_TOTAL - 1);
  localparam logic [VPOS_WIDTH-1:0] C_V_DISP   = VPOS_WIDTH'(V_DISPLAY);
  localparam logic [VPOS_WIDTH-1:0] C_VS_FIRST = VPOS_WIDTH'(V_DISPLAY + V_FRONT);
  localparam logic [VPOS_WIDTH-1:0] C_VS_LAST  = VPOS_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Status vector layout: {hsync, vsync, display_on, line_start, frame_start}.
  // The idle value holds both syncs at their inactive level.
  localparam logic [4:0] C_STAT_IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 3'b000};

  logic [C_DIV_W-1:0]    r_div;
  logic [HPOS_WIDTH-1:0] w_h_nxt;
  logic [VPOS_WIDTH-1:0] w_v_nxt;
  logic                  w_hs_act;
  logic                  w_vs_act;
  logic [4:0]            w_status;
  logic [4:0]            r_pipe [0:N_PIPE];

  // Clock divider: pixel_en is registered and pulses in the cycle after the
  // count wraps; run=0 holds the count so resuming continues the same phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= '0;
      pixel_en <= 1'b0;
    end else if (run) begin
      if (r_div == C_DIV_LAST) begin
        r_div    <= '0;
        pixel_en <= 1'b1;
      end else begin
        r_div    <= r_div + 1'b1;
        pixel_en <= 1'b0;
      end
    end else begin
      pixel_en <= 1'b0;
    end
  end

  // Next raster position and the status derived from that new position.
  always_comb begin
    w_h_nxt = hpos + 1'b1;
    w_v_nxt = vpos;
    if (hpos == C_H_LAST) begin
      w_h_nxt = '0;
      if (vpos == C_V_LAST) begin
        w_v_nxt = '0;
      end else begin
        w_v_nxt = vpos + 1'b1;
      end
    end
    w_hs_act = (w_h_nxt >= C_HS_FIRST) && (w_h_nxt <= C_HS_LAST);
    w_vs_act = (w_v_nxt >= C_VS_FIRST) && (w_v_nxt <= C_VS_LAST);
    w_status = {~(w_hs_act ^ H_SYNC_POL),
                ~(w_vs_act ^ V_SYNC_POL),
                (w_h_nxt < C_H_DISP) && (w_v_nxt < C_V_DISP),
                (w_h_nxt == '0),
                (w_h_nxt == '0) && (w_v_nxt == '0)};
  end

  // Raster counters; reset parks them on the last position so the first
  // pixel tick lands on (0,0). A pixel_en pulse already issued still
  // advances even if run drops in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos <= C_H_LAST;
      vpos <= C_V_LAST;
    end else if (pixel_en) begin
      hpos <= w_h_nxt;
      vpos <= w_v_nxt;
    end
  end

  // Status delay line: stage 0 is the registered status, each further stage
  // adds one pixel tick of delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N_PIPE; i++) begin
        r_pipe[i] <= C_STAT_IDLE;
      end
    end else if (pixel_en) begin
      r_pipe[0] <= w_status;
      for (int i = 1; i <= N_PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign {hsync, vsync, display_on, line_start, frame_start} = r_pipe[N_PIPE];

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter bumps on the undelayed (0,0) tick, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (pixel_en && w_status[0]) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
